// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, 11x128 round-key table.
// Optional macro AES_INV_AUTO_KEY_EN: ld samples key and text_in together and runs KEXP then DEC.
module aes_inv_cipher_iter #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kld,
  input  logic             ld,
  input  logic [KEY_W-1:0] key,
  input  logic [127:0]     text_in,
  output logic [127:0]     text_out,
  output logic             done,
  output logic             kdone,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_KEXP = 2'd1;
  localparam logic [1:0] S_DEC  = 2'd2;
  localparam logic [3:0] LAST   = 4'(NR);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [3:0] i);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = rk;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rcon(i), 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte b = 4*col + row lives at bits [127-8b -: 8].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      o[127-8*b -: 8] = inv_sbox(s[127-8*b -: 8]);
    end
    return o;
  endfunction

  function automatic logic [7:0] gmul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (k)
      4'h9:    return x8 ^ a;
      4'hb:    return x8 ^ x2 ^ a;
      4'hd:    return x8 ^ x4 ^ a;
      4'he:    return x8 ^ x4 ^ x2;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul_k(a0, 4'he) ^ gmul_k(a1, 4'hb) ^ gmul_k(a2, 4'hd) ^ gmul_k(a3, 4'h9);
      o[119-32*c -: 8] = gmul_k(a0, 4'h9) ^ gmul_k(a1, 4'he) ^ gmul_k(a2, 4'hb) ^ gmul_k(a3, 4'hd);
      o[111-32*c -: 8] = gmul_k(a0, 4'hd) ^ gmul_k(a1, 4'h9) ^ gmul_k(a2, 4'he) ^ gmul_k(a3, 4'hb);
      o[103-32*c -: 8] = gmul_k(a0, 4'hb) ^ gmul_k(a1, 4'hd) ^ gmul_k(a2, 4'h9) ^ gmul_k(a3, 4'he);
    end
    return o;
  endfunction

  logic [1:0]   r_fsm;
  logic [3:0]   r_rnd;
  logic         r_key_valid;
  logic         r_auto;
  logic         r_done;
  logic         r_kdone;
  logic [127:0] r_text_out;
  logic [127:0] r_blk;
  logic [127:0] r_rk [0:10];

  logic         w_idle;
  logic         w_kld_go;
  logic         w_ld_go;
  logic         w_key_go;
  logic [3:0]   w_rk_idx;
  logic [127:0] w_rk_sel;
  logic [127:0] w_kexp;
  logic [127:0] w_ark;
  logic [127:0] w_round;

  assign w_idle   = (r_fsm == S_IDLE);
  assign w_kld_go = w_idle & kld;
`ifdef AES_INV_AUTO_KEY_EN
  assign w_ld_go  = w_idle & ~kld & ld;
  assign w_key_go = w_kld_go | w_ld_go;
`else
  assign w_ld_go  = w_idle & ~kld & ld & r_key_valid;
  assign w_key_go = w_kld_go;
`endif

  // KEXP reads the previous round key; DEC reads the current round's key.
  assign w_rk_idx = (r_fsm == S_KEXP) ? (r_rnd - 4'd1) : r_rnd;
  assign w_rk_sel = (w_rk_idx <= LAST) ? r_rk[w_rk_idx] : '0;
  assign w_kexp   = key_expand(w_rk_sel, r_rnd);
  assign w_ark    = inv_sub_bytes(inv_shift_rows(r_blk)) ^ w_rk_sel;
  assign w_round  = inv_mix_columns(w_ark);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm       <= S_IDLE;
      r_rnd       <= 4'd0;
      r_key_valid <= 1'b0;
      r_auto      <= 1'b0;
      r_done      <= 1'b0;
      r_kdone     <= 1'b0;
      r_text_out  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_kdone <= 1'b0;
      case (r_fsm)
        S_IDLE: begin
          if (w_key_go) begin
            r_fsm       <= S_KEXP;
            r_rnd       <= 4'd1;
            r_key_valid <= 1'b0;
            r_auto      <= w_ld_go;
          end else if (w_ld_go) begin
            r_fsm <= S_DEC;
            r_rnd <= LAST;
          end
        end
        S_KEXP: begin
          if (r_rnd == LAST) begin
            r_kdone     <= 1'b1;
            r_key_valid <= 1'b1;
            r_auto      <= 1'b0;
            r_fsm       <= r_auto ? S_DEC : S_IDLE;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        S_DEC: begin
          if (r_rnd == 4'd0) begin
            r_text_out <= w_ark;
            r_done     <= 1'b1;
            r_fsm      <= S_IDLE;
          end else begin
            r_rnd <= r_rnd - 4'd1;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  // Datapath registers: key table and block state carry no reset.
  always_ff @(posedge clk) begin
    if (w_key_go) r_rk[0] <= key;
    if (r_fsm == S_KEXP && r_rnd != 4'd0 && r_rnd <= LAST) r_rk[r_rnd] <= w_kexp;
    if (w_ld_go) begin
      r_blk <= text_in;
    end else if (r_fsm == S_DEC) begin
      if (r_rnd == LAST)      r_blk <= r_blk ^ w_rk_sel;
      else if (r_rnd != 4'd0) r_blk <= w_round;
    end
  end

  assign text_out = r_text_out;
  assign done     = r_done;
  assign kdone    = r_kdone;
  assign busy     = (r_fsm != S_IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter (default build: explicit kld before ld).
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         kld;
  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic [127:0] text_out;
  logic         done;
  logic         kdone;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT2 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT3 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT3 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT4 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT4 = 128'h3243f6a8885a308d313198a2e0370734;

  aes_inv_cipher_iter #(.NR(10), .KEY_W(128)) dut (
    .clk      (clk),
    .rst      (rst),
    .kld      (kld),
    .ld       (ld),
    .key      (key),
    .text_in  (text_in),
    .text_out (text_out),
    .done     (done),
    .kdone    (kdone),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single edge; returns 1ns after the accepting edge.
  task automatic start(input logic do_kld, input logic do_ld, input logic [127:0] k,
                       input logic [127:0] t);
    kld     = do_kld;
    ld      = do_ld;
    key     = k;
    text_in = t;
    tick();
    kld = 1'b0;
    ld  = 1'b0;
  endtask

  // Cycles until the selected pulse, or -1 if the budget expires.
  task automatic wait_pulse(input logic sel_kdone, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if ((sel_kdone ? kdone : done) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int cd, output int ck);
    cd = 0;
    ck = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (done === 1'b1)  cd++;
      if (kdone === 1'b1) ck++;
    end
  endtask

  task automatic decrypt(input string tag, input logic [127:0] ct, input logic [127:0] pt);
    int lat;
    start(1'b0, 1'b1, '0, ct);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd1);
    wait_pulse(1'b0, 30, lat);
    chk_int({tag, "_lat"}, lat, 11);
    chk({tag, "_pt"}, text_out, pt);
  endtask

  initial begin
    int lat, cd, ck;
    rst = 1'b0; kld = 1'b0; ld = 1'b0; key = '0; text_in = '0;
    repeat (3) tick();
    chk("rst_text_out", text_out, '0);
    chk("rst_done", {127'd0, done}, 128'd0);
    chk("rst_kdone", {127'd0, kdone}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    rst = 1'b1;
    tick();

    // ld without any key is dropped
    start(1'b0, 1'b1, '0, CT1);
    chk("nokey_busy", {127'd0, busy}, 128'd0);
    count_pulses(30, cd, ck);
    chk_int("nokey_done", cd, 0);

    // FIPS-197 C.1 key expansion then decryption
    start(1'b1, 1'b0, K1, '0);
    chk("kexp_busy", {127'd0, busy}, 128'd1);
    wait_pulse(1'b1, 20, lat);
    chk_int("kexp_lat", lat, 10);
    chk("kdone_idle", {127'd0, busy}, 128'd0);
    tick();
    chk("kdone_width", {127'd0, kdone}, 128'd0);
    decrypt("c1", CT1, PT1);

    // Back-to-back: ld asserted in the done cycle, no new kld
    start(1'b0, 1'b1, '0, CT1);
    chk("done_width", {127'd0, done}, 128'd0);
    chk("b2b_busy", {127'd0, busy}, 128'd1);
    wait_pulse(1'b0, 30, lat);
    chk_int("b2b_lat", lat, 11);
    chk("b2b_pt", text_out, PT1);

    // ld and kld while decrypting are ignored
    start(1'b0, 1'b1, '0, CT1);
    repeat (3) tick();
    start(1'b1, 1'b1, K2, CT2);
    count_pulses(20, cd, ck);
    chk_int("busy_ign_done", cd, 1);
    chk_int("busy_ign_kdone", ck, 0);
    chk("busy_ign_pt", text_out, PT1);

    // ld during key expansion is dropped
    start(1'b1, 1'b0, K2, '0);
    repeat (3) tick();
    start(1'b0, 1'b1, '0, CT2);
    count_pulses(20, cd, ck);
    chk_int("kexp_ign_done", cd, 0);
    chk_int("kexp_ign_kdone", ck, 1);

    // kld and ld together: kld wins
    start(1'b1, 1'b1, K2, CT2);
    count_pulses(20, cd, ck);
    chk_int("both_kdone", ck, 1);
    chk_int("both_done", cd, 0);
    chk("both_text_held", text_out, PT1);

    decrypt("ecb1", CT2, PT2);
    decrypt("ecb2", CT3, PT3);
    decrypt("fipsb", CT4, PT4);

    // Reset in the middle of a decryption
    start(1'b0, 1'b1, '0, CT2);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mrst_text_out", text_out, '0);
    chk("mrst_busy", {127'd0, busy}, 128'd0);
    chk("mrst_done", {127'd0, done}, 128'd0);
    count_pulses(20, cd, ck);
    chk_int("mrst_no_done", cd, 0);
    start(1'b0, 1'b1, '0, CT2);
    chk("mrst_ld_busy", {127'd0, busy}, 128'd0);
    count_pulses(30, cd, ck);
    chk_int("mrst_ld_done", cd, 0);

    // Recovery with a fresh key
    start(1'b1, 1'b0, K1, '0);
    wait_pulse(1'b1, 20, lat);
    chk_int("rec_kexp_lat", lat, 10);
    decrypt("rec", CT1, PT1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
